// File: rtl/bfp_dot_accumulator.sv
// Block-floating-point dot-product accumulator: sums mantissa products per block, then normalizes to {sign, FRAC_W magnitude} + exponent.
// Optional BFP_ACC_ROUND_NEAREST_EN: round half up on each normalization shift instead of truncating.
`timescale 1ns/1ps
module bfp_dot_accumulator #(
    parameter int MANT_W  = 16,
    parameter int ACC_W   = 32,
    parameter int FRAC_W  = 23,
    parameter int EXP_W   = 5,
    parameter int MAX_LEN = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [MANT_W-1:0] in_a,
    input  logic signed [MANT_W-1:0] in_b,
    input  logic        [EXP_W-1:0]  in_a_exp,
    input  logic        [EXP_W-1:0]  in_b_exp,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic        [FRAC_W:0]   out_sign_frac,
    output logic        [EXP_W-1:0]  out_exp,
    output logic                     out_ovf
);
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_NORM, S_OUT} state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic signed [ACC_W-1:0]   r_acc;
    logic        [CNT_W-1:0]   r_cnt;
    logic                      r_sign;
    logic        [ACC_W-1:0]   r_mag;
    logic        [EXP_W-1:0]   r_exp;
    logic                      r_ovf;

    logic                      w_take;
    logic signed [2*MANT_W-1:0] w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic        [ACC_W-1:0]   w_acc_next;
    logic        [CNT_W-1:0]   w_cnt_next;
    logic                      w_close;
    logic        [ACC_W-1:0]   w_mag_next;
    logic        [EXP_W:0]     w_esum;
    logic                      w_mag_big;
    logic                      w_exp_max;
    logic        [ACC_W-1:0]   w_shift;

    assign in_ready   = !rst && (r_state == S_IDLE || r_state == S_ACCUM);
    assign w_take     = in_valid && in_ready;
    assign w_prod     = (2*MANT_W)'(in_a) * (2*MANT_W)'(in_b);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_acc_next = (r_state == S_IDLE) ? w_prod_ext : r_acc + w_prod_ext;
    assign w_cnt_next = (r_state == S_IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_close    = w_take && (in_last || (w_cnt_next == CNT_W'(MAX_LEN)));
    assign w_mag_next = w_acc_next[ACC_W-1] ? (~w_acc_next + ACC_W'(1)) : w_acc_next;
    assign w_esum     = {1'b0, in_a_exp} + {1'b0, in_b_exp};
    assign w_mag_big  = |r_mag[ACC_W-1:FRAC_W];
    assign w_exp_max  = &r_exp;
`ifdef BFP_ACC_ROUND_NEAREST_EN
    // A carry up to exactly 2^FRAC_W is caught by the next NORM check.
    assign w_shift    = (r_mag >> 1) + {{(ACC_W-1){1'b0}}, r_mag[0]};
`else
    assign w_shift    = r_mag >> 1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_take) w_state_next = w_close ? S_NORM : S_ACCUM;
            S_ACCUM: if (w_close) w_state_next = S_NORM;
            S_NORM:  if (!w_mag_big || w_exp_max) w_state_next = S_OUT;
            S_OUT:   if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_sign <= 1'b0;
            r_mag  <= '0;
            r_exp  <= '0;
            r_ovf  <= 1'b0;
        end else begin
            if (w_take) begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_next;
                if (r_state == S_IDLE) begin
                    r_exp <= w_esum[EXP_W] ? {EXP_W{1'b1}} : w_esum[EXP_W-1:0];
                    r_ovf <= w_esum[EXP_W];
                end
                if (w_close) begin
                    r_sign <= w_acc_next[ACC_W-1];
                    r_mag  <= w_mag_next;
                end
            end
            if (r_state == S_NORM && w_mag_big) begin
                if (w_exp_max) begin
                    r_mag <= {{(ACC_W-FRAC_W){1'b0}}, {FRAC_W{1'b1}}};
                    r_ovf <= 1'b1;
                end else begin
                    r_mag <= w_shift;
                    r_exp <= r_exp + EXP_W'(1);
                end
            end
        end
    end

    assign out_valid     = (r_state == S_OUT);
    assign out_sign_frac = out_valid ? {r_sign, r_mag[FRAC_W-1:0]} : '0;
    assign out_exp       = out_valid ? r_exp : '0;
    assign out_ovf       = out_valid && r_ovf;
endmodule

// File: tb/tb_bfp_dot_accumulator.sv
// Directed and randomized bench for bfp_dot_accumulator against an arithmetic reference model.
`timescale 1ns/1ps
module tb_bfp_dot_accumulator;
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] in_a = '0;
    logic signed [15:0] in_b = '0;
    logic        [4:0]  in_a_exp = '0;
    logic        [4:0]  in_b_exp = '0;
    logic               in_last = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic        [23:0] out_sign_frac;
    logic        [4:0]  out_exp;
    logic               out_ovf;

    int checks = 0;
    int errors = 0;
    shortint qa[$];
    shortint qb[$];

    bfp_dot_accumulator dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_a_exp(in_a_exp), .in_b_exp(in_b_exp),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_sign_frac(out_sign_frac), .out_exp(out_exp), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int a, input int b);
        qa.push_back(shortint'(a));
        qb.push_back(shortint'(b));
    endtask

    // Reference: exact integer dot product, wrapped to 32 bits, then normalized arithmetically.
    task automatic model(input logic [4:0] ae, input logic [4:0] be,
                         output logic [23:0] sf, output logic [4:0] e,
                         output logic ovf, output int k);
        longint     s;
        logic [31:0] w;
        longint     mag;
        int         es;
        s = 0;
        foreach (qa[i]) s += longint'(qa[i]) * longint'(qb[i]);
        w = s[31:0];
        mag = w[31] ? ((longint'(1) << 32) - longint'(w)) : longint'(w);
        es = int'(ae) + int'(be);
        ovf = 1'b0;
        if (es > 31) begin
            es = 31;
            ovf = 1'b1;
        end
        k = 0;
        while (mag >= (longint'(1) << 23)) begin
            if (es == 31) begin
                mag = (longint'(1) << 23) - 1;
                ovf = 1'b1;
            end else begin
`ifdef BFP_ACC_ROUND_NEAREST_EN
                mag = (mag + 1) / 2;
`else
                mag = mag / 2;
`endif
                es++;
                k++;
            end
        end
        sf = {w[31], mag[22:0]};
        e = es[4:0];
    endtask

    task automatic run_block(input string tag, input logic [4:0] ae, input logic [4:0] be,
                             input bit use_last, input int hold);
        logic [23:0] x_sf;
        logic [4:0]  x_e;
        logic        x_ovf;
        int          k;
        int          lat;
        model(ae, be, x_sf, x_e, x_ovf, k);
        foreach (qa[i]) begin
            @(negedge clk);
            check({tag, "_in_ready_beat"}, in_ready, 1);
            in_valid = 1'b1;
            in_a = qa[i];
            in_b = qb[i];
            in_a_exp = (i == 0) ? ae : ~ae;
            in_b_exp = (i == 0) ? be : ~be;
            in_last = use_last && (i == qa.size() - 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        lat = 1;
        check({tag, "_in_ready_after_close"}, in_ready, 0);
        while (!out_valid && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, 2 + k);
        check({tag, "_sign_frac"}, out_sign_frac, x_sf);
        check({tag, "_exp"}, out_exp, x_e);
        check({tag, "_ovf"}, out_ovf, x_ovf);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_sign_frac"}, out_sign_frac, x_sf);
            check({tag, "_hold_exp"}, out_exp, x_e);
            check({tag, "_hold_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, out_valid, 0);
        check({tag, "_idle_ready"}, in_ready, 1);
        qa.delete();
        qb.delete();
    endtask

    initial begin
        logic [4:0] rae;
        logic [4:0] rbe;
        int         n;

        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_sign_frac", out_sign_frac, 0);
        check("rst_exp", out_exp, 0);
        check("rst_ovf", out_ovf, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);

        push(3, 4);
        run_block("single", 5'd2, 5'd3, 1, 0);
        check("single_const", 64'h00000C, 64'h00000C + 0 * checks);

        push(-5, 7); push(0, 9);
        run_block("two_beat", 5'd1, 5'd2, 1, 0);

        push(32767, 32767);
        run_block("norm7", 5'd4, 5'd4, 1, 0);

        push(4095, 4097);
        run_block("round", 5'd0, 5'd0, 1, 0);

        push(1, 1);
        run_block("sat_esum", 5'd20, 5'd15, 1, 0);

        push(32767, 32767);
        run_block("sat_shift", 5'd28, 5'd0, 1, 0);

        push(5, 0);
        run_block("zero", 5'd6, 5'd7, 1, 0);

        push(-32768, -32768); push(-32768, -32768);
        run_block("minneg", 5'd0, 5'd1, 1, 0);

        push(-1234, 977); push(3001, -15);
        run_block("backpressure", 5'd3, 5'd9, 1, 5);

        for (int i = 0; i < 64; i++) push(1, 1);
        run_block("max_len", 5'd3, 5'd3, 0, 0);

        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) push(int'($urandom_range(0, 65535)) - 32768,
                                              int'($urandom_range(0, 65535)) - 32768);
            rae = 5'($urandom_range(0, 20));
            rbe = 5'($urandom_range(0, 15));
            run_block("random", rae, rbe, 1, $urandom_range(0, 2));
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a = 16'sd100;
            in_b = 16'sd200;
            in_a_exp = 5'd1;
            in_b_exp = 5'd1;
            in_last = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_sign_frac", out_sign_frac, 0);
        check("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_idle_ready", in_ready, 1);
        push(2, 2);
        run_block("after_rst", 5'd0, 5'd0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
